// File: rtl/coin_input_conditioner_if.sv
// rtl/coin_input_conditioner_if.sv - pin-side and FSM-side signal bundle for the coin input conditioner
interface coin_input_conditioner_if;
  logic tick;
  logic m_raw;
  logic a_raw;
  logic btnC_raw;
  logic btnD_raw;
  logic m_evt;
  logic a_evt;
  logic btnC_db;
  logic btnD_db;
  logic overrun;

  modport master (
    output tick, m_raw, a_raw, btnC_raw, btnD_raw,
    input  m_evt, a_evt, btnC_db, btnD_db, overrun
  );

  modport slave (
    input  tick, m_raw, a_raw, btnC_raw, btnD_raw,
    output m_evt, a_evt, btnC_db, btnD_db, overrun
  );
endinterface

// File: rtl/coin_input_conditioner.sv
// rtl/coin_input_conditioner.sv - synchronize, debounce and tick-align coin and button inputs
module coin_input_conditioner #(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_W      = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  coin_input_conditioner_if.slave  io
);

  // Channel order: 0 = coin m, 1 = coin a, 2 = button C, 3 = button D.
  localparam int                 NCH      = 4;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [NCH-1:0]   raw;
  logic [NCH-1:0]   s1_q;
  logic [NCH-1:0]   s2_q;
  logic [NCH-1:0]   db_q;
  logic [NCH-1:0]   db_d;
  logic [NCH-1:0]   db_prev_q;
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];

  logic pend_m_q, pend_m_d;
  logic pend_a_q, pend_a_d;
  logic m_evt_q,  m_evt_d;
  logic a_evt_q,  a_evt_d;
  logic overrun_q, overrun_d;

  logic rise_m, rise_a;
  logic eff_m,  eff_a;

  assign raw = {io.btnD_raw, io.btnC_raw, io.a_raw, io.m_raw};

  // Debounce: db follows sync only after DEB_CYCLES consecutive disagreeing cycles.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (s2_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          db_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Rising edges of the debounced coin levels; a same-cycle edge counts as pending.
  assign rise_m = db_q[0] & ~db_prev_q[0];
  assign rise_a = db_q[1] & ~db_prev_q[1];
  assign eff_m  = pend_m_q | rise_m;
  assign eff_a  = pend_a_q | rise_a;

  // Event issue on tick: m wins a tie, a stays pending for the following tick.
  always_comb begin
    overrun_d = overrun_q | (rise_m & pend_m_q) | (rise_a & pend_a_q);
    pend_m_d  = eff_m;
    pend_a_d  = eff_a;
    m_evt_d   = m_evt_q;
    a_evt_d   = a_evt_q;
    if (io.tick) begin
      m_evt_d = 1'b0;
      a_evt_d = 1'b0;
      if (eff_m) begin
        m_evt_d  = 1'b1;
        pend_m_d = 1'b0;
      end else if (eff_a) begin
        a_evt_d  = 1'b1;
        pend_a_d = 1'b0;
      end
    end
  end

  // Two-flop synchronizers plus debounce state for all four channels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      s1_q      <= raw;
      s2_q      <= s1_q;
      db_q      <= db_d;
      db_prev_q <= db_q;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Pending flags, registered coin events and the sticky overrun flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_m_q  <= 1'b0;
      pend_a_q  <= 1'b0;
      m_evt_q   <= 1'b0;
      a_evt_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      pend_m_q  <= pend_m_d;
      pend_a_q  <= pend_a_d;
      m_evt_q   <= m_evt_d;
      a_evt_q   <= a_evt_d;
      overrun_q <= overrun_d;
    end
  end

  assign io.m_evt   = m_evt_q;
  assign io.a_evt   = a_evt_q;
  assign io.btnC_db = db_q[2];
  assign io.btnD_db = db_q[3];
  assign io.overrun = overrun_q;

endmodule

// File: tb/tb_coin_input_conditioner.sv
// tb/tb_coin_input_conditioner.sv - scoreboard bench for coin_input_conditioner
module tb_coin_input_conditioner;

  localparam int DEB = 4;
  localparam int HL  = DEB + 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  coin_input_conditioner_if io();

  coin_input_conditioner #(.DEB_CYCLES(DEB), .CNT_W(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (io)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  logic [4:0] expq[$];

  // Reference model state: raw history per channel, debounced levels, coin bookkeeping.
  bit rh [4][HL];
  bit dbv [4];
  bit dbold [4];
  bit pm, pa, me, ae, ov;

  int  tper = 8;
  int  tcnt = 0;
  bit  tick_always = 1'b0;
  bit  prev_rstn = 1'b0;

  function automatic logic [4:0] dut_out();
    return {io.overrun, io.btnD_db, io.btnC_db, io.a_evt, io.m_evt};
  endfunction

  task automatic model_clear();
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < HL; j++) rh[c][j] = 1'b0;
      dbv[c]   = 1'b0;
      dbold[c] = 1'b0;
    end
    pm = 0; pa = 0; me = 0; ae = 0; ov = 0;
  endtask

  // One clk edge of the reference: sync is raw delayed two edges; a debounced level
  // flips once the last DEB synchronized samples all disagree with it.
  task automatic model_step(input bit rstn, input bit [3:0] raw, input bit tk);
    bit rise [4];
    bit nd [4];
    bit all_diff;
    bit effm, effa;
    if (!rstn) begin
      model_clear();
    end else begin
      for (int c = 0; c < 4; c++) begin
        for (int j = HL - 1; j > 0; j--) rh[c][j] = rh[c][j-1];
        rh[c][0] = raw[c];
        rise[c] = dbv[c] & ~dbold[c];
        all_diff = 1'b1;
        for (int j = 2; j < HL; j++) if (rh[c][j] == dbv[c]) all_diff = 1'b0;
        nd[c] = all_diff ? ~dbv[c] : dbv[c];
      end
      for (int c = 0; c < 4; c++) begin
        dbold[c] = dbv[c];
        dbv[c]   = nd[c];
      end
      if ((rise[0] && pm) || (rise[1] && pa)) ov = 1'b1;
      effm = pm | rise[0];
      effa = pa | rise[1];
      if (tk) begin
        me = 0; ae = 0;
        if (effm) begin
          me = 1; pm = 0; pa = effa;
        end else if (effa) begin
          ae = 1; pa = 0; pm = 0;
        end else begin
          pm = 0; pa = 0;
        end
      end else begin
        pm = effm; pa = effa;
      end
    end
    expq.push_back({ov, dbv[3], dbv[2], ae, me});
  endtask

  // Drive one cycle of inputs at the falling edge and record the expected result.
  task automatic cyc(input bit [3:0] raw, input bit rstn);
    bit tk;
    @(negedge clk);
    cycle++;
    tk = tick_always || (tcnt == 0);
    tcnt = (tcnt + 1) % tper;
    io.m_raw    = raw[0];
    io.a_raw    = raw[1];
    io.btnC_raw = raw[2];
    io.btnD_raw = raw[3];
    io.tick     = tk;
    reset_n     = rstn;
    if (prev_rstn && !rstn) begin
      #1;
      checks++;
      if (dut_out() !== 5'b0) begin
        errors++;
        $display("FAIL async_reset cycle %0d got %b exp 00000", cycle, dut_out());
      end
    end
    prev_rstn = rstn;
    model_step(rstn, raw, tk);
  endtask

  task automatic hold(input bit [3:0] raw, input int n);
    for (int i = 0; i < n; i++) cyc(raw, 1'b1);
  endtask

  // Monitor: compares every registered output vector against the scoreboard head.
  initial begin
    logic [4:0] exp_v;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        exp_v = expq.pop_front();
        checks++;
        if (dut_out() !== exp_v) begin
          errors++;
          $display("FAIL outputs cycle %0d got %b exp %b (ov,btnD,btnC,a,m)", cycle, dut_out(), exp_v);
        end
      end
    end
  end

  initial begin
    bit [3:0] lvl;
    bit [3:0] drv;
    int rst_left;
    io.tick = 0; io.m_raw = 0; io.a_raw = 0; io.btnC_raw = 0; io.btnD_raw = 0;
    model_clear();

    // Reset then idle.
    for (int i = 0; i < 3; i++) cyc(4'b0000, 1'b0);
    hold(4'b0000, 40);

    // m bounces 1/0/1 then holds.
    cyc(4'b0001, 1'b1); cyc(4'b0000, 1'b1);
    hold(4'b0001, 30);
    hold(4'b0000, 30);

    // btnC short pulse, then a long press.
    hold(4'b0100, 3);
    hold(4'b0000, 12);
    hold(4'b0100, 10);
    hold(4'b0000, 20);

    // Simultaneous coins.
    hold(4'b0011, 40);
    hold(4'b0000, 20);

    // Two m presses inside one long tick period.
    tper = 60; tcnt = 1;
    hold(4'b0001, 8); hold(4'b0000, 8); hold(4'b0001, 8); hold(4'b0000, 8);
    hold(4'b0000, 90);
    tper = 8; tcnt = 0;

    // Reset while a_evt is high and another a is pending.
    for (int i = 0; i < 3; i++) cyc(4'b0000, 1'b0);
    hold(4'b0000, 4);
    hold(4'b0010, 10); hold(4'b0000, 8); hold(4'b0010, 10);
    for (int i = 0; i < 2; i++) cyc(4'b0010, 1'b0);
    hold(4'b0000, 40);

    // Randomized traffic: slow level changes, glitches, tick bursts and occasional resets.
    lvl = 4'b0000;
    rst_left = 0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 99) == 0) tick_always = ~tick_always;
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 24) == 0) lvl[c] = ~lvl[c];
        drv[c] = ($urandom_range(0, 7) == 0) ? ~lvl[c] : lvl[c];
      end
      if (rst_left == 0 && $urandom_range(0, 399) == 0) rst_left = $urandom_range(1, 3);
      if (rst_left > 0) begin
        rst_left--;
        cyc(drv, 1'b0);
      end else begin
        cyc(drv, 1'b1);
      end
    end
    tick_always = 1'b0;
    hold(4'b0000, 30);

    repeat (3) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries exp 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/coin_input_conditioner.md
Name: coin_input_conditioner

Overview:
- Front-end stage that sits directly upstream of the vending-machine FSM top.
- Takes raw asynchronous pin inputs: coin sensors m and a, and buttons btnC and btnD.
- Synchronizes and debounces each one.
- Converts coin presses into single events held for exactly one prescaler tick period, so the slow-clock Moore FSM samples each coin once. The buttons are delivered as clean debounced levels for use as the FSM resets.

Parameters:
- DEB_CYCLES, 16, number of consecutive clk cycles a synchronized input must differ from its debounced value before the debounced value changes (minimum 2).
- CNT_W, 5, width of each debounce counter; must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
- clk  input  1  system clock (undivided board clock)
- reset_n  input  1  asynchronous active-low reset
- tick  input  1  one-clk-wide strobe, asserted once per slow-clock period by the prescaler
- m_raw  input  1  raw coin sensor "m", asynchronous, may bounce
- a_raw  input  1  raw coin sensor "a", asynchronous, may bounce
- btnC_raw  input  1  raw button C, asynchronous, may bounce
- btnD_raw  input  1  raw button D, asynchronous, may bounce
- m_evt  output  1  coin-m event, held for one full tick period
- a_evt  output  1  coin-a event, held for one full tick period
- btnC_db  output  1  debounced level of button C
- btnD_db  output  1  debounced level of button D
- overrun  output  1  sticky flag: a coin edge arrived while the same coin was already pending

Behaviour:
- Reset: reset_n low asynchronously clears all state:
  - synchronizer flops, debounced values, counters, pending flags and overrun go to 0;
  - m_evt, a_evt, btnC_db and btnD_db go to 0.
  - Reset asserted mid-debounce or mid-event discards that activity; no event is emitted after release.
- Synchronizer: two flops per input. Latency from a raw input change to the sync output is 2 clk cycles.
- Debounce, per channel, with registers db and cnt:
  - sync == db: cnt <= 0.
  - sync != db and cnt == DEB_CYCLES-1: db <= sync, cnt <= 0.
  - sync != db otherwise: cnt <= cnt+1.
  - A stable change therefore reaches db 2+DEB_CYCLES clk cycles after the raw edge.
  - Any glitch shorter than DEB_CYCLES cycles resets the count and never reaches db.
- btnC_db and btnD_db are the db registers of those channels, driven directly. No tick alignment is applied to them.
- Coin edge detection: a rising edge of db_m or db_a (db was 0 in the previous cycle, is 1 now) sets pend_m or pend_a. Falling edges are ignored.
- Overrun: a rising edge on a channel whose pend is already 1 leaves pend at 1 and sets overrun. overrun clears only on reset.
- Event issue, at a clk edge where tick == 1:
  - The effective pending value is pend, OR a rising edge detected in this same cycle.
  - Only m pending: m_evt <= 1, a_evt <= 0, pend_m <= 0.
  - Only a pending: a_evt <= 1, m_evt <= 0, pend_a <= 0.
  - Both pending (simultaneous-coin rule): m_evt <= 1, a_evt <= 0, pend_m <= 0, pend_a stays 1. a is issued at the next tick.
  - Neither pending: m_evt <= 0, a_evt <= 0.
- Between ticks: m_evt and a_evt hold their values. Each event is therefore high for exactly one tick period, never both at once.
- Pending flags hold indefinitely until a tick occurs. tick held high continuously behaves as a tick on every cycle.

Test Plan (DEB_CYCLES=4, tick every 8 clk cycles):
- Reset release, all raw inputs 0 for 40 cycles -> all outputs stay 0.
- m_raw bounces 1/0/1 at 1-cycle intervals, then stays 1 -> db_m rises exactly 6 cycles after the last transition. m_evt goes high at the first following tick and drops at the next tick. a_evt stays 0 throughout.
- btnC_raw 3-cycle pulse -> btnC_db stays 0. btnC_raw held 10 cycles -> btnC_db goes 1 after 6 cycles and returns to 0 six cycles after release.
- m_raw and a_raw rise in the same cycle, stable -> m_evt is high for one tick period, then a_evt is high for the following tick period. The two events never overlap.
- Two clean m presses complete (press, debounce, release, re-press) within one tick period -> one m_evt period and overrun = 1.
- reset_n pulsed low while pend_a = 1 and a_evt = 1 -> a_evt falls immediately (asynchronously) and no a_evt appears after release.
